// File: rtl/fetch_seq.sv
// Instruction-fetch sequencer: owns the PC and keeps one fetch outstanding to imem, then holds the word until decode takes it.
// Latency: if_valid follows rvalid by one cycle. Backpressure: while decode stalls, the held word waits and no new request is issued.
module fetch_seq #(
    parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    input  logic        if_ready
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD} state_t;

    state_t      r_state, w_state_nxt;
    logic [31:0] r_pc, w_pc_nxt;
    logic        r_kill, w_kill_nxt;
    logic        r_pend, w_pend_nxt;
    logic [31:0] r_pend_pc, w_pend_pc_nxt;
    logic        r_imem_req, w_imem_req_nxt;
    logic        r_if_valid, w_if_valid_nxt;
    logic [31:0] r_if_pc, w_if_pc_nxt;
    logic [31:0] r_if_instr, w_if_instr_nxt;
    logic [31:0] w_tgt;

    assign w_tgt     = redirect_pc & ~32'd3;
    assign imem_req  = r_imem_req;
    assign imem_addr = r_pc;
    assign if_valid  = r_if_valid;
    assign if_pc     = r_if_pc;
    assign if_instr  = r_if_instr;

    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_kill_nxt     = r_kill;
        w_pend_nxt     = r_pend;
        w_pend_pc_nxt  = r_pend_pc;
        w_if_valid_nxt = r_if_valid;
        w_if_pc_nxt    = r_if_pc;
        w_if_instr_nxt = r_if_instr;
        case (r_state)
            S_IDLE: begin
                w_state_nxt = S_REQ;
                if (redirect) w_pc_nxt = w_tgt;
            end
            S_REQ: begin
                // The address must not move while requesting, so a redirect is parked in pend_pc.
                if (imem_gnt) begin
                    w_state_nxt = S_WAIT;
                    if (redirect) begin
                        w_kill_nxt    = 1'b1;
                        w_pend_nxt    = 1'b1;
                        w_pend_pc_nxt = w_tgt;
                    end else if (r_pend) begin
                        w_kill_nxt = 1'b1;
                    end
                end else if (redirect) begin
                    w_pend_nxt    = 1'b1;
                    w_pend_pc_nxt = w_tgt;
                end
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    if (redirect) begin
                        w_pc_nxt    = w_tgt;
                        w_kill_nxt  = 1'b0;
                        w_pend_nxt  = 1'b0;
                        w_state_nxt = S_REQ;
                    end else if (r_kill) begin
                        w_pc_nxt    = r_pend_pc;
                        w_kill_nxt  = 1'b0;
                        w_pend_nxt  = 1'b0;
                        w_state_nxt = S_REQ;
                    end else begin
                        w_if_valid_nxt = 1'b1;
                        w_if_pc_nxt    = r_pc;
                        w_if_instr_nxt = imem_rdata;
                        w_state_nxt    = S_HOLD;
                    end
                end else if (redirect) begin
                    w_kill_nxt    = 1'b1;
                    w_pend_nxt    = 1'b1;
                    w_pend_pc_nxt = w_tgt;
                end
            end
            S_HOLD: begin
                // A redirect wins over pc+4 even when decode accepts in the same cycle.
                if (redirect) begin
                    w_if_valid_nxt = 1'b0;
                    w_pc_nxt       = w_tgt;
                    w_state_nxt    = S_REQ;
                end else if (if_ready) begin
                    w_if_valid_nxt = 1'b0;
                    w_pc_nxt       = r_pc + 32'd4;
                    w_state_nxt    = S_REQ;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        w_imem_req_nxt = (w_state_nxt == S_REQ);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_pc       <= RESET_PC;
            r_kill     <= 1'b0;
            r_pend     <= 1'b0;
            r_pend_pc  <= RESET_PC;
            r_imem_req <= 1'b0;
            r_if_valid <= 1'b0;
            r_if_pc    <= 32'd0;
            r_if_instr <= 32'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_kill     <= w_kill_nxt;
            r_pend     <= w_pend_nxt;
            r_pend_pc  <= w_pend_pc_nxt;
            r_imem_req <= w_imem_req_nxt;
            r_if_valid <= w_if_valid_nxt;
            r_if_pc    <= w_if_pc_nxt;
            r_if_instr <= w_if_instr_nxt;
        end
    end

endmodule

// File: tb/tb_fetch_seq.sv
// Bench for fetch_seq: reactive imem model plus queues of expected grant addresses and delivered (pc, instr) pairs.
module tb_fetch_seq;

    localparam logic [31:0] RESET_PC = 32'h0040_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        if_ready;

    fetch_seq #(.RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr), .if_ready(if_ready)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] exp_addr_q[$];
    logic [63:0] exp_if_q[$];

    int          gnt_delay = 0;
    int          rsp_delay = 0;
    logic        ovr_en    = 1'b0;
    logic [31:0] ovr_addr  = 32'd0;
    logic [31:0] ovr_data  = 32'd0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hA5C3_1E0F;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic push_addr(input logic [31:0] a);
        exp_addr_q.push_back(a);
    endtask

    task automatic push_fetch(input logic [31:0] a);
        exp_addr_q.push_back(a);
        exp_if_q.push_back({a, mem_word(a)});
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!if_valid && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(if_valid), 32'd1);
    endtask

    task automatic accept();
        wait_valid("accept_wait");
        if_ready = 1'b1;
        @(negedge clk);
        if_ready = 1'b0;
    endtask

    // Memory model: grant after gnt_delay cycles, respond rsp_delay cycles after the grant.
    initial begin
        int          gcnt = -1;
        int          rcnt = 0;
        logic        busy = 1'b0;
        logic [31:0] baddr = 32'd0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'd0;
        forever begin
            @(negedge clk);
            #1;
            imem_gnt    = 1'b0;
            imem_rvalid = 1'b0;
            if (busy) begin
                if (rcnt == 0) begin
                    imem_rvalid = 1'b1;
                    imem_rdata  = (ovr_en && baddr == ovr_addr) ? ovr_data : mem_word(baddr);
                    busy        = 1'b0;
                end else begin
                    rcnt--;
                end
            end else if (imem_req) begin
                if (gcnt < 0) gcnt = gnt_delay;
                if (gcnt == 0) begin
                    imem_gnt = 1'b1;
                    baddr    = imem_addr;
                    busy     = 1'b1;
                    rcnt     = rsp_delay;
                    gcnt     = -1;
                end else begin
                    gcnt--;
                end
            end else begin
                gcnt = -1;
            end
        end
    end

    // Scoreboard monitor, sampling mid-cycle ahead of the next rising edge.
    initial begin
        logic [31:0] ea;
        logic [63:0] ei;
        forever begin
            @(negedge clk);
            #2;
            if (rst && imem_req && imem_gnt) begin
                if (exp_addr_q.size() == 0) chk("grant_unexpected", 32'(exp_addr_q.size()), 32'd1);
                else begin
                    ea = exp_addr_q.pop_front();
                    chk("grant_addr", imem_addr, ea);
                end
            end
            if (rst && if_valid && if_ready) begin
                if (exp_if_q.size() == 0) chk("xfer_unexpected", 32'(exp_if_q.size()), 32'd1);
                else begin
                    ei = exp_if_q.pop_front();
                    chk("xfer_pc", if_pc, ei[63:32]);
                    chk("xfer_instr", if_instr, ei[31:0]);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        rst = 1'b0; redirect = 1'b0; redirect_pc = 32'd0; if_ready = 1'b0;

        // Reset and boot
        repeat (3) @(negedge clk);
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_addr", imem_addr, RESET_PC);
        chk("rst_vld", 32'(if_valid), 32'd0);
        chk("rst_if_pc", if_pc, 32'd0);
        chk("rst_if_instr", if_instr, 32'd0);
        for (int i = 0; i < 4; i++) push_fetch(RESET_PC + 32'(4 * i));
        rst = 1'b1;
        chk("boot_idle_req", 32'(imem_req), 32'd0);
        @(negedge clk);
        chk("boot_first_req", 32'(imem_req), 32'd1);
        chk("boot_first_addr", imem_addr, RESET_PC);
        repeat (3) accept();

        // Backpressure in HOLD
        wait_valid("bp_vld");
        for (int i = 0; i < 5; i++) begin
            chk("bp_vld_stable", 32'(if_valid), 32'd1);
            chk("bp_pc_stable", if_pc, 32'h0040_000C);
            chk("bp_instr_stable", if_instr, mem_word(32'h0040_000C));
            chk("bp_no_req", 32'(imem_req), 32'd0);
            @(negedge clk);
        end
        push_addr(32'h0040_0010);
        ovr_en = 1'b1; ovr_addr = 32'h0040_0010; ovr_data = 32'hDEAD_BEEF;
        rsp_delay = 3;
        if_ready = 1'b1;
        @(negedge clk);
        if_ready = 1'b0;
        chk("bp_next_req", 32'(imem_req), 32'd1);
        chk("bp_next_addr", imem_addr, 32'h0040_0010);

        // Redirect while waiting for the response
        @(negedge clk);
        push_fetch(32'h0040_0100);
        redirect = 1'b1; redirect_pc = 32'h0040_0100;
        @(negedge clk);
        redirect = 1'b0;
        rsp_delay = 0;
        wait_valid("rw_vld");
        chk("rw_pc", if_pc, 32'h0040_0100);
        chk("rw_instr", if_instr, mem_word(32'h0040_0100));

        // Redirect in REQ before grant
        push_fetch(32'h0040_0104);
        accept();
        wait_valid("rq_hold_vld");
        chk("rq_hold_pc", if_pc, 32'h0040_0104);
        gnt_delay = 4;
        push_addr(32'h0040_0108);
        if_ready = 1'b1;
        @(negedge clk);
        if_ready = 1'b0;
        @(negedge clk);
        push_fetch(32'h0040_0200);
        redirect = 1'b1; redirect_pc = 32'h0040_0203;
        @(negedge clk);
        redirect = 1'b0;
        chk("rq_req_held", 32'(imem_req), 32'd1);
        chk("rq_addr_held", imem_addr, 32'h0040_0108);
        @(negedge clk);
        chk("rq_addr_held2", imem_addr, 32'h0040_0108);
        gnt_delay = 0;
        wait_valid("rq_vld");
        chk("rq_pc", if_pc, 32'h0040_0200);
        chk("rq_instr", if_instr, mem_word(32'h0040_0200));

        // Redirect and accept together in HOLD
        push_addr(32'h0000_0040);
        if_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000_0040;
        @(negedge clk);
        if_ready = 1'b0; redirect = 1'b0;
        chk("ra_vld_drop", 32'(if_valid), 32'd0);
        chk("ra_req", 32'(imem_req), 32'd1);
        chk("ra_addr", imem_addr, 32'h0000_0040);
        wait_valid("ra_vld");
        chk("ra_pc", if_pc, 32'h0000_0040);
        chk("ra_instr", if_instr, mem_word(32'h0000_0040));

        // Wrap past the top of the address space
        push_fetch(32'hFFFF_FFFC);
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFF;
        @(negedge clk);
        redirect = 1'b0;
        chk("wr_vld_drop", 32'(if_valid), 32'd0);
        wait_valid("wr_vld");
        chk("wr_pc", if_pc, 32'hFFFF_FFFC);
        push_addr(32'h0000_0000);
        ovr_addr = 32'h0000_0000;
        rsp_delay = 6;
        if_ready = 1'b1;
        @(negedge clk);
        if_ready = 1'b0;
        chk("wr_req", 32'(imem_req), 32'd1);
        chk("wr_addr", imem_addr, 32'h0000_0000);

        // Reset while WAIT, stale response arrives after release
        @(negedge clk);
        push_fetch(RESET_PC);
        rst = 1'b0;
        @(negedge clk);
        rsp_delay = 0;
        chk("mr_req", 32'(imem_req), 32'd0);
        chk("mr_vld", 32'(if_valid), 32'd0);
        chk("mr_addr", imem_addr, RESET_PC);
        @(negedge clk);
        rst = 1'b1;
        wait_valid("mr_refetch_vld");
        chk("mr_pc", if_pc, RESET_PC);
        chk("mr_instr", if_instr, mem_word(RESET_PC));

        push_addr(RESET_PC + 32'd4);
        accept();
        repeat (10) @(negedge clk);
        chk("drain_addr_q", 32'(exp_addr_q.size()), 32'd0);
        chk("drain_if_q", 32'(exp_if_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
